// File: rtl/clk_enable_gen_if.sv
// Control/status bundle for clk_enable_gen: lock input, rate configuration,
// phase clear, and the ready/enable outputs.
interface clk_enable_gen_if #(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 24
);
    logic                pll_locked;
    logic                sync_clr;
    logic                cfg_we;
    logic [3:0]          cfg_ch;
    logic [ACC_W-1:0]    cfg_inc;
    logic                ready;
    logic [CHANNELS-1:0] ce;

    modport master (
        output pll_locked, sync_clr, cfg_we, cfg_ch, cfg_inc,
        input  ready, ce
    );

    modport slave (
        input  pll_locked, sync_clr, cfg_we, cfg_ch, cfg_inc,
        output ready, ce
    );
endinterface

// File: rtl/clk_enable_gen.sv
// Fractional clock-enable generator: one phase accumulator per channel, all
// gated until the PLL lock flag has been stable for LOCK_WAIT cycles.
module clk_enable_gen #(
    parameter int                        CHANNELS  = 4,
    parameter int                        ACC_W     = 24,
    parameter int                        LOCK_WAIT = 1024,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT  = {CHANNELS*ACC_W{1'b0}}
) (
    input  logic             refclk,
    input  logic             rst,
    clk_enable_gen_if.slave  ctl
);
    localparam int CNT_W = $clog2(LOCK_WAIT + 1);

    logic             lk_meta_q;
    logic             lk_sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ready_q;
    logic             ready_d;
    logic             acc_clr;
    logic [CHANNELS-1:0] ce_vec;

    // Settle counter saturates at LOCK_WAIT; any unlocked sample restarts it.
    always_comb begin
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        if (!lk_sync_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_W'(LOCK_WAIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            ready_d = (cnt_q == CNT_W'(LOCK_WAIT));
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta_q <= 1'b0;
            lk_sync_q <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            lk_meta_q <= ctl.pll_locked;
            lk_sync_q <= lk_meta_q;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Lock loss takes priority; sync_clr only matters while running.
    assign acc_clr = !lk_sync_q || !ready_q || ctl.sync_clr;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [ACC_W-1:0] inc_q;
            logic [ACC_W-1:0] acc_q;
            logic             ce_q;
            logic [ACC_W:0]   sum_d;

            assign sum_d = {1'b0, acc_q} + {1'b0, inc_q};

            always_ff @(posedge refclk or posedge rst) begin
                if (rst) begin
                    inc_q <= INC_INIT[gi*ACC_W +: ACC_W];
                    acc_q <= '0;
                    ce_q  <= 1'b0;
                end else begin
                    if (ctl.cfg_we && (ctl.cfg_ch == 4'(gi))) begin
                        inc_q <= ctl.cfg_inc;
                    end
                    if (acc_clr) begin
                        acc_q <= '0;
                        ce_q  <= 1'b0;
                    end else begin
                        {ce_q, acc_q} <= sum_d;
                    end
                end
            end

            assign ce_vec[gi] = ce_q;
        end
    endgenerate

    assign ctl.ready = ready_q;
    assign ctl.ce    = ce_vec;
endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: settle, rates, lock loss, reprogramming,
// phase clear and asynchronous reset, with hand-computed expectations.
module tb_clk_enable_gen;
    localparam int CH = 4;
    localparam int AW = 8;
    localparam int LW = 4;
    localparam logic [CH*AW-1:0] INIT = {8'd0, 8'd96, 8'd128, 8'd64};

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    clk_enable_gen_if #(.CHANNELS(CH), .ACC_W(AW)) bus ();

    clk_enable_gen #(
        .CHANNELS (CH),
        .ACC_W    (AW),
        .LOCK_WAIT(LW),
        .INC_INIT (INIT)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .ctl   (bus)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    logic [3:0] hist [1:64];
    logic [3:0] exp_rst [1:8];
    int c0, c1, c2, c3, first0;
    logic [7:0] pat;
    logic alt_ok;

    initial begin
        exp_rst[1] = 4'h0; exp_rst[2] = 4'h2; exp_rst[3] = 4'h4; exp_rst[4] = 4'h3;
        exp_rst[5] = 4'h0; exp_rst[6] = 4'h6; exp_rst[7] = 4'h0; exp_rst[8] = 4'h7;

        bus.pll_locked = 1'b0;
        bus.sync_clr   = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = 4'd0;
        bus.cfg_inc    = 8'd0;
        rst = 1'b1;
        tick(); tick();
        check_eq("reset_ready", 32'(bus.ready), 32'd0);
        check_eq("reset_ce", 32'(bus.ce), 32'd0);
        bus.pll_locked = 1'b1;
        tick(); tick();
        check_eq("reset_locked_ready", 32'(bus.ready), 32'd0);
        rst = 1'b0;

        // ready is 0 for 6 edges after release and 1 on the 7th
        for (int n = 1; n <= 7; n++) begin
            tick();
            check_eq($sformatf("settle_ready_%0d", n), 32'(bus.ready), 32'(n == 7));
            check_eq($sformatf("settle_ce_%0d", n), 32'(bus.ce), 32'd0);
        end

        c0 = 0; c1 = 0; c2 = 0; c3 = 0; first0 = 0; alt_ok = 1'b1; pat = '0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            hist[k] = bus.ce;
        end
        for (int k = 1; k <= 64; k++) begin
            c0 += int'(hist[k][0]);
            c1 += int'(hist[k][1]);
            c2 += int'(hist[k][2]);
            c3 += int'(hist[k][3]);
            if (hist[k][0] && first0 == 0) first0 = k;
            if (hist[k][1] != (k % 2 == 0)) alt_ok = 1'b0;
            if (k <= 8) pat[k-1] = hist[k][2];
        end
        check_eq("rate_ce0_count", 32'(c0), 32'd16);
        check_eq("rate_ce1_count", 32'(c1), 32'd32);
        check_eq("rate_ce2_count", 32'(c2), 32'd24);
        check_eq("rate_ce3_count", 32'(c3), 32'd0);
        check_eq("rate_ce0_first", 32'(first0), 32'd4);
        check_eq("rate_ce1_alternating", 32'(alt_ok), 32'd1);
        check_eq("rate_ce2_pattern", 32'(pat), 32'hA4);

        // one-cycle lock drop: ready falls on the 3rd edge, returns on the 8th
        bus.pll_locked = 1'b0;
        tick();
        check_eq("lockloss_ready_e1", 32'(bus.ready), 32'd1);
        bus.pll_locked = 1'b1;
        tick();
        check_eq("lockloss_ready_e2", 32'(bus.ready), 32'd1);
        tick();
        check_eq("lockloss_ready_e3", 32'(bus.ready), 32'd0);
        check_eq("lockloss_ce_e3", 32'(bus.ce), 32'd0);
        for (int e = 4; e <= 8; e++) begin
            tick();
            check_eq($sformatf("relock_ready_e%0d", e), 32'(bus.ready), 32'(e == 8));
            check_eq($sformatf("relock_ce_e%0d", e), 32'(bus.ce), 32'd0);
        end
        pat = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            pat[k-1] = bus.ce[0];
        end
        check_eq("relock_ce0_first4", 32'(pat[3:0]), 32'h8);

        // ch3 -> 255: accumulator starts at 0, so first carry is 2 edges later
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 4'd3;
        bus.cfg_inc = 8'd255;
        tick();
        bus.cfg_we  = 1'b0;
        tick();
        check_eq("reprog_ce3_w1", 32'(bus.ce[3]), 32'd0);
        tick();
        check_eq("reprog_ce3_w2", 32'(bus.ce[3]), 32'd1);
        c3 = 1;
        for (int j = 3; j <= 256; j++) begin
            tick();
            c3 += int'(bus.ce[3]);
        end
        check_eq("reprog_ce3_count256", 32'(c3), 32'd255);
        tick();
        check_eq("reprog_ce3_gap", 32'(bus.ce[3]), 32'd0);
        tick();
        check_eq("reprog_ce3_resume", 32'(bus.ce[3]), 32'd1);

        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 4'd7;
        bus.cfg_inc = 8'd0;
        tick();
        bus.cfg_we  = 1'b0;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            c0 += int'(bus.ce[0]);
            c1 += int'(bus.ce[1]);
            c2 += int'(bus.ce[2]);
            c3 += int'(bus.ce[3]);
        end
        check_eq("ch7_ce0_count16", 32'(c0), 32'd4);
        check_eq("ch7_ce1_count16", 32'(c1), 32'd8);
        check_eq("ch7_ce2_count16", 32'(c2), 32'd6);
        check_eq("ch7_ce3_count16", 32'(c3), 32'd16);

        // sync_clr plus ch0 -> 128 in the same edge
        bus.sync_clr = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 4'd0;
        bus.cfg_inc  = 8'd128;
        tick();
        bus.sync_clr = 1'b0;
        bus.cfg_we   = 1'b0;
        check_eq("sclr_ce_c0", 32'(bus.ce), 32'd0);
        tick();
        check_eq("sclr_ce_c1", 32'(bus.ce), 32'd0);
        for (int j = 2; j <= 9; j++) begin
            tick();
            check_eq($sformatf("sclr_ce10_c%0d", j), 32'(bus.ce[1:0]), (j % 2 == 0) ? 32'd3 : 32'd0);
        end

        // asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_ready", 32'(bus.ready), 32'd0);
        check_eq("arst_ce", 32'(bus.ce), 32'd0);
        @(posedge refclk);
        #1;
        rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            tick();
        end
        check_eq("arst_resettle_ready", 32'(bus.ready), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq($sformatf("arst_init_ce_k%0d", k), 32'(bus.ce), 32'(exp_rst[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised successor to the fixed-ratio PLL wrapper.
- Takes the single PLL output clock (refclk) and the PLL lock flag, and produces CHANNELS independent single-cycle clock enables.
- Each enable has a fractional, runtime-programmable rate, so slow domains (CPU, sound, video) run from one clock instead of extra PLL outputs.
- Enables are gated until lock has been stable for a programmable settle time.

Parameters:
- CHANNELS, 4, number of enable outputs (1..16).
- ACC_W, 24, phase-accumulator width per channel; rate = f_refclk * inc / 2^ACC_W.
- LOCK_WAIT, 1024, consecutive synchronised-locked cycles required before ready asserts (>=1).
- INC_INIT, {CHANNELS*ACC_W{1'b0}}, packed per-channel reset increments; channel i at bits [i*ACC_W +: ACC_W].

Ports:
- refclk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- pll_locked, in, 1, PLL lock flag, asynchronous to refclk.
- sync_clr, in, 1, synchronous clear of all accumulators (phase alignment).
- cfg_we, in, 1, increment write strobe.
- cfg_ch, in, 4, channel index for write.
- cfg_inc, in, ACC_W, new increment value.
- ready, out, 1, lock stable and enables running.
- ce, out, CHANNELS, single-cycle enable pulses, bit i = channel i.

Behaviour:
- Reset (rst high, async):
  - sync flops = 0, settle counter = 0, ready = 0.
  - All accumulators = 0, ce = 0.
  - inc[i] = INC_INIT slice i.
- Lock synchroniser:
  - pll_locked passes through 2 flops to give lk_s.
  - lk_s=0: counter = 0, ready = 0 next cycle.
  - lk_s=1: counter increments, saturating at LOCK_WAIT.
  - ready is registered; it goes 1 in the cycle after the counter reaches LOCK_WAIT.
  - Minimum rst-release to ready = 2 + LOCK_WAIT + 1 cycles.
- Lock loss: lk_s=0 at any time gives next cycle ready=0, all accumulators=0, ce=0. Increments are kept.
- Accumulator update, per cycle, while ready=1:
  - {carry, acc[i]} <= acc[i] + inc[i], computed at ACC_W+1 bits, wrapping modulo 2^ACC_W.
  - ce[i] <= carry, registered from the same addition.
  - While ready=0: acc held at 0, ce=0.
- Rate rules:
  - inc=0: ce never pulses.
  - inc=2^(ACC_W-1): ce pulses every 2nd cycle.
  - inc=2^ACC_W-1: ce high on all cycles except 1 in 2^ACC_W.
  - ce is never high for 2 consecutive cycles unless inc > 2^(ACC_W-1).
- sync_clr=1 (ready=1): all acc <= 0 and ce <= 0 next cycle. Accumulation restarts the following cycle, so all channels are phase-aligned.
- Config write:
  - cfg_we=1 with cfg_ch < CHANNELS: inc[cfg_ch] <= cfg_inc.
  - The new value is used by the addition in the following cycle; the accumulator is not cleared.
  - cfg_ch >= CHANNELS: write ignored.
  - Writes are accepted regardless of ready.
- Simultaneous events:
  - sync_clr and cfg_we in the same cycle: both take effect, acc cleared and inc updated.
  - Lock loss overrides sync_clr.
  - rst overrides everything.
- No other state. All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Bench parameters: ACC_W=8, LOCK_WAIT=4, INC_INIT={8'd0,8'd96,8'd128,8'd64}.
- Lock settle: release rst, hold pll_locked=1 -> ready=0 for 6 cycles, 1 on the 7th; ce=0 throughout.
- Rates: after ready, run 64 cycles ->
  - ce[0] (inc 64): pulses every 4th cycle, first pulse 4 cycles after ready; 16 pulses total.
  - ce[1] (inc 128): 32 pulses, alternating.
  - ce[2] (inc 96): 24 pulses, repeating 3-per-8 pattern.
  - ce[3] (inc 0): 0 pulses.
- Lock loss: drop pll_locked for 1 cycle mid-run -> ready falls 3 cycles later, ce=0, and on re-lock ready returns after a full LOCK_WAIT settle; first ce[0] is again 4 cycles after ready.
- Runtime reprogram: write cfg_ch=3, cfg_inc=255 -> ce[3] pulses on 255 of every 256 cycles, starting the 2nd cycle after the write. A write with cfg_ch=7 changes no channel.
- sync_clr with simultaneous cfg_we (ch0, inc 128): ce all 0 the next cycle, then ce[0] pulses every 2nd cycle and ce[1] is aligned with it.
- Async reset mid-run: assert rst between clock edges -> ready, ce and accumulators are 0 immediately, and increments return to INC_INIT.
